// File: rtl/line_matrix_pkg.sv
// rtl/line_matrix_pkg.sv - shared constants and helpers for the GPI line matrix
package line_matrix_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_DISCONNECT = '1;
  localparam int N_IN_DEF = 10;
  localparam int N_OUT_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF = 3;

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel, input int n);
    return int'(sel) < n;
  endfunction

endpackage

// File: rtl/line_matrix_in_if.sv
// rtl/line_matrix_in_if.sv - cfg strobe bus, accessory inputs and routed outputs
interface line_matrix_in_if #(
  parameter int N_IN  = line_matrix_pkg::N_IN_DEF,
  parameter int N_OUT = line_matrix_pkg::N_OUT_DEF
);

  logic                                  cfg_clk;
  logic                                  cfg_rstn;
  logic [line_matrix_pkg::SEL_W-1:0]     cfg_in_sel;
  logic [line_matrix_pkg::SEL_W-1:0]     cfg_out_sel;
  logic [N_IN-1:0]                       input_lines;
  logic [N_OUT-1:0]                      output_lines;
  logic [N_OUT*line_matrix_pkg::SEL_W-1:0] map_rd;

  modport master (
    output cfg_clk, cfg_rstn, cfg_in_sel, cfg_out_sel, input_lines,
    input  output_lines, map_rd
  );

  modport slave (
    input  cfg_clk, cfg_rstn, cfg_in_sel, cfg_out_sel, input_lines,
    output output_lines, map_rd
  );

endinterface

// File: rtl/line_matrix_filt.sv
// rtl/line_matrix_filt.sv - synchronizer plus glitch filter for one async line
module line_matrix_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign dout = sample;
    end else begin : g_filt
      localparam int CNT_W = $clog2(FILT_LEN + 1);
      logic [CNT_W-1:0] cnt_q;
      logic             filt_q;

      // cnt tracks how long the sample has disagreed with the filtered value
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (sample == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
          filt_q <= sample;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign dout = filt_q;
    end
  endgenerate

endmodule

// File: rtl/line_matrix_in.sv
// rtl/line_matrix_in.sv - runtime-programmable crossbar from accessory inputs to RFIC CTRL_IN lines
module line_matrix_in
  import line_matrix_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int N_OUT       = N_OUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  line_matrix_in_if.slave  bus
);

  localparam int LINES_W = 2 ** SEL_W;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] rstn_sync;
  logic [SEL_W-1:0]       in_sel_sync  [SYNC_STAGES];
  logic [SEL_W-1:0]       out_sel_sync [SYNC_STAGES];
  logic                   clk_hist;
  logic                   cfg_edge;
  logic                   cfg_clear;
  logic [SEL_W-1:0]       wr_in_sel;
  logic [SEL_W-1:0]       wr_out_sel;
  logic [SEL_W-1:0]       map_q [N_OUT];
  logic [N_IN-1:0]        filt;
  logic [LINES_W-1:0]     filt_ext;
  logic [N_OUT-1:0]       out_q;

  // cfg_clk chain and history start high so a strobe held high through reset never writes
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      clk_sync  <= '1;
      clk_hist  <= 1'b1;
      rstn_sync <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        in_sel_sync[s]  <= '0;
        out_sel_sync[s] <= '0;
      end
    end else begin
      clk_sync        <= {clk_sync[SYNC_STAGES-2:0], bus.cfg_clk};
      rstn_sync       <= {rstn_sync[SYNC_STAGES-2:0], bus.cfg_rstn};
      clk_hist        <= clk_sync[SYNC_STAGES-1];
      in_sel_sync[0]  <= bus.cfg_in_sel;
      out_sel_sync[0] <= bus.cfg_out_sel;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        in_sel_sync[s]  <= in_sel_sync[s-1];
        out_sel_sync[s] <= out_sel_sync[s-1];
      end
    end
  end

  assign cfg_edge   = clk_sync[SYNC_STAGES-1] & ~clk_hist;
  assign cfg_clear  = ~rstn_sync[SYNC_STAGES-1];
  assign wr_in_sel  = in_sel_sync[SYNC_STAGES-1];
  assign wr_out_sel = out_sel_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (rst || cfg_clear) begin
      for (int j = 0; j < N_OUT; j++) map_q[j] <= SEL_DISCONNECT;
    end else if (cfg_edge && sel_valid(wr_out_sel, N_OUT)) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (wr_out_sel == SEL_W'(j)) map_q[j] <= wr_in_sel;
      end
    end
  end

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_line
      line_matrix_filt #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
      ) u_filt (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (bus.input_lines[i]),
        .dout (filt[i])
      );
    end
  endgenerate

  // zero-extend so every select code indexes a real bit; invalid codes are masked anyway
  assign filt_ext = LINES_W'(filt);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        out_q[j] <= sel_valid(map_q[j], N_IN) ? filt_ext[map_q[j]] : 1'b0;
      end
    end
  end

  always_comb begin
    bus.map_rd = '0;
    for (int j = 0; j < N_OUT; j++) bus.map_rd[j*SEL_W +: SEL_W] = map_q[j];
  end

  assign bus.output_lines = out_q;

endmodule

// File: tb/tb_line_matrix_in.sv
// tb/tb_line_matrix_in.sv - directed bench for the GPI line matrix
module tb_line_matrix_in;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  line_matrix_in_if #(.N_IN(10), .N_OUT(8)) bus ();

  line_matrix_in #(
    .N_IN(10), .N_OUT(8), .SYNC_STAGES(2), .FILT_LEN(3)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [3:0] o, input logic [3:0] i);
    bus.cfg_out_sel = o;
    bus.cfg_in_sel  = i;
    repeat (4) @(negedge clk);
    bus.cfg_clk = 1'b1;
    repeat (5) @(negedge clk);
    bus.cfg_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cfg_clk = 1'b1;
    bus.cfg_rstn = 1'b1;
    bus.cfg_in_sel = 4'd1;
    bus.cfg_out_sel = 4'd0;
    bus.input_lines = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.map_rd !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL reset_map: got %h expected %h", bus.map_rd, 32'hFFFF_FFFF);
    end
    tests++;
    if (bus.output_lines !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: got %h expected %h", bus.output_lines, 8'h00);
    end
    bus.cfg_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_route;
    logic [7:0] exp;
    cfg_write(4'd2, 4'd5);
    tests++;
    if (bus.map_rd !== 32'hFFFF_F5FF) begin
      fails++;
      $display("FAIL route_map: got %h expected %h", bus.map_rd, 32'hFFFF_F5FF);
    end
    bus.input_lines[5] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp = (k == 6) ? 8'h04 : 8'h00;
      tests++;
      if (bus.output_lines !== exp) begin
        fails++;
        $display("FAIL route_latency_%0d: got %h expected %h", k, bus.output_lines, exp);
      end
    end
    bus.input_lines[5] = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.output_lines !== 8'h00) begin
      fails++;
      $display("FAIL route_fall: got %h expected %h", bus.output_lines, 8'h00);
    end
  endtask

  task automatic test_pulse;
    int high_cnt;
    int other_cnt;
    int exp_cnt;
    for (int w = 1; w <= 3; w++) begin
      high_cnt = 0;
      other_cnt = 0;
      exp_cnt = (w == 3) ? 3 : 0;
      bus.input_lines[5] = 1'b1;
      repeat (w) @(negedge clk);
      bus.input_lines[5] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (bus.output_lines[2] === 1'b1) high_cnt++;
        if ((bus.output_lines & 8'hFB) !== 8'h00) other_cnt++;
        @(negedge clk);
      end
      tests++;
      if (high_cnt != exp_cnt || other_cnt != 0) begin
        fails++;
        $display("FAIL pulse_w%0d: got %0d high cycles (%0d stray) expected %0d (0 stray)",
                 w, high_cnt, other_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_bad_sel;
    cfg_write(4'd9, 4'd3);
    tests++;
    if (bus.map_rd !== 32'hFFFF_F5FF) begin
      fails++;
      $display("FAIL bad_out_sel: got %h expected %h", bus.map_rd, 32'hFFFF_F5FF);
    end
    cfg_write(4'd2, 4'd12);
    tests++;
    if (bus.map_rd !== 32'hFFFF_FCFF) begin
      fails++;
      $display("FAIL bad_in_sel_map: got %h expected %h", bus.map_rd, 32'hFFFF_FCFF);
    end
    bus.input_lines = 10'h3FF;
    repeat (12) @(negedge clk);
    tests++;
    if (bus.output_lines !== 8'h00) begin
      fails++;
      $display("FAIL bad_in_sel_out: got %h expected %h", bus.output_lines, 8'h00);
    end
    bus.input_lines = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_clear_race;
    cfg_write(4'd4, 4'd1);
    tests++;
    if (bus.map_rd !== 32'hFFF1_FCFF) begin
      fails++;
      $display("FAIL clear_pre_map: got %h expected %h", bus.map_rd, 32'hFFF1_FCFF);
    end
    bus.cfg_out_sel = 4'd6;
    bus.cfg_in_sel  = 4'd2;
    repeat (4) @(negedge clk);
    bus.cfg_clk  = 1'b1;
    bus.cfg_rstn = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.map_rd !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL clear_map: got %h expected %h", bus.map_rd, 32'hFFFF_FFFF);
    end
    bus.cfg_rstn = 1'b1;
    repeat (6) @(negedge clk);
    bus.cfg_clk = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.map_rd !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL clear_discard: got %h expected %h", bus.map_rd, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_rst_mid;
    cfg_write(4'd0, 4'd3);
    cfg_write(4'd7, 4'd3);
    tests++;
    if (bus.map_rd !== 32'h3FFF_FFF3) begin
      fails++;
      $display("FAIL share_map: got %h expected %h", bus.map_rd, 32'h3FFF_FFF3);
    end
    bus.input_lines[3] = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.output_lines !== 8'h81) begin
      fails++;
      $display("FAIL share_out: got %h expected %h", bus.output_lines, 8'h81);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.output_lines !== 8'h00 || bus.map_rd !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL rst_mid: got out %h map %h expected out 00 map ffffffff",
               bus.output_lines, bus.map_rd);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cfg_write(4'd1, 4'd3);
    tests++;
    if (bus.map_rd !== 32'hFFFF_FF3F) begin
      fails++;
      $display("FAIL reprog_map: got %h expected %h", bus.map_rd, 32'hFFFF_FF3F);
    end
    tests++;
    if (bus.output_lines !== 8'h02) begin
      fails++;
      $display("FAIL reprog_out: got %h expected %h", bus.output_lines, 8'h02);
    end
    bus.input_lines = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bus.cfg_clk     = 1'b1;
    bus.cfg_rstn    = 1'b1;
    bus.cfg_in_sel  = '0;
    bus.cfg_out_sel = '0;
    bus.input_lines = '0;
    @(negedge clk);
    test_reset();
    test_route();
    test_pulse();
    test_bad_sel();
    test_clear_race();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
